// File: rtl/hls_cdp_ocvt_pkg.sv
// Shared definitions for the CDP output-convert input skid buffers.
//   - skid_state_e : skid buffer occupancy (EMPTY/ONE/FULL); encoding 3 is
//                    unused and is treated as EMPTY by the decoder.
//   - CDP_OCVT_DW      : default payload width of chn_data_in.
//   - CDP_OCVT_PERF_CW : width of the optional starvation counter.
package hls_cdp_ocvt_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    localparam int CDP_OCVT_DW      = 16;
    localparam int CDP_OCVT_PERF_CW = 32;

endpackage

// File: rtl/hls_cdp_ocvt_chn_data_in_skid.sv
// Two-entry registered skid buffer in front of the CDP output-convert core's
// chn_data_in wait-control. Converts the upstream valid/ready pipe into the
// core-side vd/ld handshake without a combinational ready path and without
// bubbles at full throughput. Standalone so it can be replicated per channel.
//
// Optional feature (macro HLS_CDP_OCVT_SKID_PERF_EN): adds skid_starve_cnt,
// a saturating count of cycles where the core strobes ld with no data.
//
// Ports:
//   nvdla_core_clk       in   clock, rising edge
//   nvdla_core_rst       in   asynchronous active-high reset
//   chn_data_in_vld      in   upstream valid
//   chn_data_in_rdy      out  upstream ready (registered)
//   chn_data_in_pd       in   upstream payload [DW]
//   chn_data_in_rsci_vd  out  core-side valid (head entry present)
//   chn_data_in_rsci_d   out  core-side payload (head entry) [DW]
//   chn_data_in_rsci_ld  in   core consume strobe
//   skid_starve_cnt      out  starvation counter [32] (feature only)
//
// state      | meaning
// SKID_EMPTY | no entries; main holds a stale value
// SKID_ONE   | head valid in main
// SKID_FULL  | head in main, second beat in skid; upstream stalled
module hls_cdp_ocvt_chn_data_in_skid
    import hls_cdp_ocvt_pkg::*;
#(
    parameter int DW = CDP_OCVT_DW
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rst,
    input  logic          chn_data_in_vld,
    output logic          chn_data_in_rdy,
    input  logic [DW-1:0] chn_data_in_pd,
    output logic          chn_data_in_rsci_vd,
    output logic [DW-1:0] chn_data_in_rsci_d,
    input  logic          chn_data_in_rsci_ld
`ifdef HLS_CDP_OCVT_SKID_PERF_EN
    ,
    output logic [CDP_OCVT_PERF_CW-1:0] skid_starve_cnt
`endif
);

    skid_state_e   state, next_state;
    logic [DW-1:0] main_q, skid_q;
    logic          rdy_q;
    logic          vd;
    logic          push, pop;
    logic          main_en, main_from_skid, skid_en;

    assign vd   = (state == SKID_ONE) || (state == SKID_FULL);
    assign push = chn_data_in_vld && rdy_q;
    assign pop  = chn_data_in_rsci_ld && vd;

    always_comb begin
        next_state     = state;
        main_en        = 1'b0;
        main_from_skid = 1'b0;
        skid_en        = 1'b0;
        case (state)
            SKID_ONE: begin
                if (push && !pop) begin
                    next_state = SKID_FULL;
                    skid_en    = 1'b1;
                end else if (push && pop) begin
                    main_en = 1'b1;
                end else if (pop) begin
                    next_state = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                // rdy is low here, so only a pop can happen
                if (pop) begin
                    next_state     = SKID_ONE;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                // SKID_EMPTY, and the unused encoding behaves the same way
                if (push) begin
                    next_state = SKID_ONE;
                    main_en    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state  <= SKID_EMPTY;
            rdy_q  <= 1'b1;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= next_state;
            // ready looks one cycle ahead so the upstream never sees a
            // combinational path from the core's ld
            rdy_q <= (next_state != SKID_FULL);
            if (main_en) begin
                main_q <= main_from_skid ? skid_q : chn_data_in_pd;
            end
            if (skid_en) begin
                skid_q <= chn_data_in_pd;
            end
        end
    end

    assign chn_data_in_rdy     = rdy_q;
    assign chn_data_in_rsci_vd = vd;
    assign chn_data_in_rsci_d  = main_q;

`ifdef HLS_CDP_OCVT_SKID_PERF_EN
    logic [CDP_OCVT_PERF_CW-1:0] starve_q;

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            starve_q <= '0;
        end else if (chn_data_in_rsci_ld && !vd && (starve_q != '1)) begin
            starve_q <= starve_q + 1'b1;
        end
    end

    assign skid_starve_cnt = starve_q;
`endif

endmodule

// File: tb/tb_hls_cdp_ocvt_chn_data_in_skid.sv
// Bench for hls_cdp_ocvt_chn_data_in_skid: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based model of a two-deep FIFO.
module tb_hls_cdp_ocvt_chn_data_in_skid;

    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic          vld;
    logic          rdy;
    logic [DW-1:0] pd;
    logic          vd;
    logic [DW-1:0] d;
    logic          ld;
`ifdef HLS_CDP_OCVT_SKID_PERF_EN
    logic [31:0]   starve;
`endif

    int n_checks = 0;
    int n_errors = 0;

    hls_cdp_ocvt_chn_data_in_skid #(.DW(DW)) dut (
        .nvdla_core_clk      (clk),
        .nvdla_core_rst      (rst),
        .chn_data_in_vld     (vld),
        .chn_data_in_rdy     (rdy),
        .chn_data_in_pd      (pd),
        .chn_data_in_rsci_vd (vd),
        .chn_data_in_rsci_d  (d),
        .chn_data_in_rsci_ld (ld)
`ifdef HLS_CDP_OCVT_SKID_PERF_EN
        ,
        .skid_starve_cnt     (starve)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a FIFO of capacity two. Ready means "room left",
    // valid means "not empty", data is the oldest beat.
    logic [DW-1:0] q[$];
    logic [31:0]   m_starve;
    logic          m_push, m_pop;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_starve = 0;
        end else begin
            m_push = vld && (q.size() < 2);
            m_pop  = ld && (q.size() > 0);
            if (ld && q.size() == 0 && m_starve != 32'hFFFF_FFFF) m_starve = m_starve + 1;
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back(pd);
        end
    end

    always @(posedge clk) begin
        #2;
        check("model_vd", {31'd0, vd}, {31'd0, q.size() > 0});
        check("model_rdy", {31'd0, rdy}, {31'd0, q.size() < 2});
        if (q.size() > 0) check("model_d", {16'd0, d}, {16'd0, q[0]});
`ifdef HLS_CDP_OCVT_SKID_PERF_EN
        check("model_starve", starve, m_starve);
`endif
    end

    task automatic step();
        @(negedge clk);
    endtask

    logic [31:0] cnt0;

    initial begin
        rst = 1'b1; vld = 1'b0; ld = 1'b0; pd = '0;
        step(); step();
        check("rst_rdy", {31'd0, rdy}, 32'd1);
        check("rst_vd", {31'd0, vd}, 32'd0);
        check("rst_d", {16'd0, d}, 32'd0);
        rst = 1'b0;

        // first beat after reset
        vld = 1'b1; pd = 16'h00A5;
        step();
        check("first_vd", {31'd0, vd}, 32'd1);
        check("first_d", {16'd0, d}, 32'h00A5);
        vld = 1'b0; ld = 1'b1;
        step();
        check("first_drain_vd", {31'd0, vd}, 32'd0);
        ld = 1'b0;

        // full throughput: 100 beats, one per cycle
        vld = 1'b1; ld = 1'b1; pd = 16'd0;
        for (int i = 0; i < 100; i++) begin
            step();
            check("tput_vd", {31'd0, vd}, 32'd1);
            check("tput_d", {16'd0, d}, i);
            check("tput_rdy", {31'd0, rdy}, 32'd1);
            pd = 16'(i + 1);
        end
        vld = 1'b0;
        step();
        check("tput_end_vd", {31'd0, vd}, 32'd0);
        ld = 1'b0;

        // backpressure fill
        vld = 1'b1; pd = 16'h0011;
        step();
        check("fill1_rdy", {31'd0, rdy}, 32'd1);
        check("fill1_d", {16'd0, d}, 32'h0011);
        pd = 16'h0022;
        step();
        check("fill2_rdy", {31'd0, rdy}, 32'd0);
        check("fill2_d", {16'd0, d}, 32'h0011);
        pd = 16'h0033;
        for (int i = 0; i < 2; i++) begin
            step();
            check("held_rdy", {31'd0, rdy}, 32'd0);
            check("held_d", {16'd0, d}, 32'h0011);
        end

        // drain from full while 0033 is still offered
        ld = 1'b1;
        step();
        check("drain1_d", {16'd0, d}, 32'h0022);
        check("drain1_rdy", {31'd0, rdy}, 32'd1);
        step();
        check("drain2_d", {16'd0, d}, 32'h0033);
        check("drain2_vd", {31'd0, vd}, 32'd1);
        vld = 1'b0;
        step();
        check("drain3_vd", {31'd0, vd}, 32'd0);

        // spurious ld while empty
`ifdef HLS_CDP_OCVT_SKID_PERF_EN
        cnt0 = starve;
`else
        cnt0 = 0;
`endif
        for (int i = 0; i < 5; i++) begin
            step();
            check("spur_vd", {31'd0, vd}, 32'd0);
            check("spur_rdy", {31'd0, rdy}, 32'd1);
        end
`ifdef HLS_CDP_OCVT_SKID_PERF_EN
        check("spur_starve", starve - cnt0, 32'd5);
`endif
        ld = 1'b0;

        // reset while full
        vld = 1'b1; pd = 16'h0011;
        step();
        pd = 16'h0022;
        step();
        check("prerst_rdy", {31'd0, rdy}, 32'd0);
        vld = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_vd", {31'd0, vd}, 32'd0);
        check("midrst_rdy", {31'd0, rdy}, 32'd1);
        step();
        rst = 1'b0;
        vld = 1'b1; pd = 16'h0044;
        step();
        check("postrst_d", {16'd0, d}, 32'h0044);
        vld = 1'b0; ld = 1'b1;
        step();
        check("postrst_vd", {31'd0, vd}, 32'd0);
        ld = 1'b0;

        // randomized traffic; upstream holds vld/pd while stalled
        for (int c = 0; c < 3000; c++) begin
            step();
            if (c == 1500) rst = 1'b1;
            if (c == 1502) rst = 1'b0;
            if (!(vld && !rdy)) begin
                vld = ($urandom_range(0, 3) != 0);
                pd  = 16'($urandom);
            end
            ld = ($urandom_range(0, 2) != 0) ? 1'b1 : (($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
            if (c >= 1000 && c < 1300) ld = ($urandom_range(0, 4) == 0);
        end
        vld = 1'b0; ld = 1'b0;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
